// File: rtl/mem_access_pkg.sv
// +----------------------------------------------------------------------+
// | mem_access_pkg                                                       |
// | Op codes, FSM state encoding, byte-enable patterns and bus helpers.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_access_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LW  = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LB  = 4'd4,
        OP_LBU = 4'd5,
        OP_SW  = 4'd6,
        OP_SH  = 4'd7,
        OP_SB  = 4'd8
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [3:0] c_BE_WORD    = 4'b1111;
    localparam logic [3:0] c_BE_HALF_LO = 4'b0011;
    localparam logic [3:0] c_BE_HALF_HI = 4'b1100;
    localparam logic [3:0] c_BE_BYTE0   = 4'b0001;

    function automatic logic is_load_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_SW, OP_SH, OP_SB: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return is_load_op(op) | is_store_op(op);
    endfunction

    // Loads mark the lanes they read with the same pattern a store of that size would use.
    function automatic logic [3:0] access_be(input logic [3:0] op, input logic [1:0] lo);
        logic [3:0] r;
        case (op)
            OP_LW, OP_SW:         r = c_BE_WORD;
            OP_LH, OP_LHU, OP_SH: r = lo[1] ? c_BE_HALF_HI : c_BE_HALF_LO;
            OP_LB, OP_LBU, OP_SB: r = c_BE_BYTE0 << lo;
            default:              r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] r;
        case (op)
            OP_SW:   r = d;
            OP_SH:   r = {2{d[15:0]}};
            OP_SB:   r = {4{d[7:0]}};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic r;
        case (op)
            OP_LW, OP_SW:         r = (lo != 2'b00);
            OP_LH, OP_LHU, OP_SH: r = lo[0];
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_load_ext.sv
// +----------------------------------------------------------------------+
// | mem_load_ext                                                         |
// | Little-endian lane select and sign/zero extension of load data.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    always_comb begin
        o_data = 32'h0000_0000;
        case (i_op)
            OP_LW:   o_data = i_rdata;
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0000, w_half};
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'h00_0000, w_byte};
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// +----------------------------------------------------------------------+
// | mem_access                                                           |
// | M-stage memory access unit: single-outstanding bus FSM with timeout. |
// | Optional alignment exception: define MEM_ALIGN_CHECK_EN.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
)
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  OpE,
    input  logic [31:0] AddrE,
    input  logic [31:0] StoreDataE,
    input  logic [4:0]  A3E,
    input  logic [31:0] ALUResE,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusBe,
    input  logic        BusReady,
    input  logic [31:0] BusRData,
    output logic        StallM,
    output logic [4:0]  A3M,
    output logic [31:0] WDM,
    output logic        BusErrM,
    output logic        ExcM
);

    localparam int              CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_e             r_state,       w_state_nxt;
    logic               r_bus_req,     w_bus_req_nxt;
    logic               r_bus_we,      w_bus_we_nxt;
    logic [31:0]        r_bus_addr,    w_bus_addr_nxt;
    logic [31:0]        r_bus_wdata,   w_bus_wdata_nxt;
    logic [3:0]         r_bus_be,      w_bus_be_nxt;
    logic [3:0]         r_op,          w_op_nxt;
    logic [1:0]         r_addr_lo,     w_addr_lo_nxt;
    logic [4:0]         r_dest,        w_dest_nxt;
    logic [CNT_W-1:0]   r_cnt,         w_cnt_nxt;
    logic [4:0]         r_a3m,         w_a3m_nxt;
    logic [31:0]        r_wdm,         w_wdm_nxt;
    logic               r_bus_err,     w_bus_err_nxt;
    logic [31:0]        w_ld_data;
    logic               w_timeout;
    logic               w_misal;

`ifdef MEM_ALIGN_CHECK_EN
    logic               r_exc;

    assign w_misal = is_misaligned(OpE, AddrE[1:0]);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_exc <= 1'b0;
        end else begin
            r_exc <= (r_state == ST_IDLE) && is_mem_op(OpE) && w_misal;
        end
    end

    assign ExcM = r_exc;
`else
    assign w_misal = 1'b0;
    assign ExcM    = 1'b0;
`endif

    mem_load_ext u_load_ext (
        .i_op      (r_op),
        .i_addr_lo (r_addr_lo),
        .i_rdata   (BusRData),
        .o_data    (w_ld_data)
    );

    assign w_timeout = (TIMEOUT_CYC > 0) && (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_bus_be_nxt    = r_bus_be;
        w_op_nxt        = r_op;
        w_addr_lo_nxt   = r_addr_lo;
        w_dest_nxt      = r_dest;
        w_cnt_nxt       = r_cnt;
        w_a3m_nxt       = 5'd0;
        w_wdm_nxt       = 32'h0000_0000;
        w_bus_err_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_bus_req_nxt   = 1'b0;
                w_bus_we_nxt    = 1'b0;
                w_bus_addr_nxt  = 32'h0000_0000;
                w_bus_wdata_nxt = 32'h0000_0000;
                w_bus_be_nxt    = 4'b0000;
                w_cnt_nxt       = '0;
                if (!is_mem_op(OpE)) begin
                    w_a3m_nxt = A3E;
                    w_wdm_nxt = ALUResE;
                end else if (!w_misal) begin
                    w_state_nxt     = ST_ACCESS;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = is_store_op(OpE);
                    w_bus_addr_nxt  = {AddrE[31:2], 2'b00};
                    w_bus_wdata_nxt = store_wdata(OpE, StoreDataE);
                    w_bus_be_nxt    = access_be(OpE, AddrE[1:0]);
                    w_op_nxt        = OpE;
                    w_addr_lo_nxt   = AddrE[1:0];
                    w_dest_nxt      = A3E;
                end
            end

            ST_ACCESS: begin
                // Completion takes priority over a timeout expiring on the same edge.
                if (BusReady || w_timeout) begin
                    w_state_nxt     = ST_IDLE;
                    w_bus_req_nxt   = 1'b0;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_addr_nxt  = 32'h0000_0000;
                    w_bus_wdata_nxt = 32'h0000_0000;
                    w_bus_be_nxt    = 4'b0000;
                    w_cnt_nxt       = '0;
                    if (BusReady) begin
                        if (is_load_op(r_op)) begin
                            w_a3m_nxt = r_dest;
                            w_wdm_nxt = w_ld_data;
                        end
                    end else begin
                        w_bus_err_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_wdata <= 32'h0000_0000;
            r_bus_be    <= 4'b0000;
            r_op        <= 4'd0;
            r_addr_lo   <= 2'b00;
            r_dest      <= 5'd0;
            r_cnt       <= '0;
            r_a3m       <= 5'd0;
            r_wdm       <= 32'h0000_0000;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_bus_be    <= w_bus_be_nxt;
            r_op        <= w_op_nxt;
            r_addr_lo   <= w_addr_lo_nxt;
            r_dest      <= w_dest_nxt;
            r_cnt       <= w_cnt_nxt;
            r_a3m       <= w_a3m_nxt;
            r_wdm       <= w_wdm_nxt;
            r_bus_err   <= w_bus_err_nxt;
        end
    end

    assign StallM   = (r_state == ST_ACCESS);
    assign BusReq   = r_bus_req;
    assign BusWe    = r_bus_we;
    assign BusAddr  = r_bus_addr;
    assign BusWData = r_bus_wdata;
    assign BusBe    = r_bus_be;
    assign A3M      = r_a3m;
    assign WDM      = r_wdm;
    assign BusErrM  = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// +----------------------------------------------------------------------+
// | tb_mem_access                                                        |
// | Vector table plus writeback scoreboard for mem_access (timeout 4).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_access;

    localparam logic [3:0] c_NOP = 4'd0;
    localparam logic [3:0] c_LW  = 4'd1;
    localparam logic [3:0] c_LH  = 4'd2;
    localparam logic [3:0] c_LHU = 4'd3;
    localparam logic [3:0] c_LB  = 4'd4;
    localparam logic [3:0] c_LBU = 4'd5;
    localparam logic [3:0] c_SW  = 4'd6;
    localparam logic [3:0] c_SH  = 4'd7;
    localparam logic [3:0] c_SB  = 4'd8;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  a3;
        logic [31:0] alures;
        logic [31:0] rdata;
        int          delay;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd;
    } vec_t;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
    } wb_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  OpE;
    logic [31:0] AddrE;
    logic [31:0] StoreDataE;
    logic [4:0]  A3E;
    logic [31:0] ALUResE;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic [3:0]  BusBe;
    logic        BusReady;
    logic [31:0] BusRData;
    logic        StallM;
    logic [4:0]  A3M;
    logic [31:0] WDM;
    logic        BusErrM;
    logic        ExcM;

    int   n_checks = 0;
    int   n_errors = 0;
    wb_t  sb[$];
    vec_t vecs[15];

    always #5 Clk = ~Clk;

    mem_access #(.TIMEOUT_CYC(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .OpE        (OpE),
        .AddrE      (AddrE),
        .StoreDataE (StoreDataE),
        .A3E        (A3E),
        .ALUResE    (ALUResE),
        .BusReq     (BusReq),
        .BusWe      (BusWe),
        .BusAddr    (BusAddr),
        .BusWData   (BusWData),
        .BusBe      (BusBe),
        .BusReady   (BusReady),
        .BusRData   (BusRData),
        .StallM     (StallM),
        .A3M        (A3M),
        .WDM        (WDM),
        .BusErrM    (BusErrM),
        .ExcM       (ExcM)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_a3m"}, 32'(A3M), 32'(e.a3));
        chk({tag, "_wdm"}, WDM, e.wd);
    endtask

    task automatic drive_nop(input logic [4:0] a3, input logic [31:0] res);
        OpE        = c_NOP;
        AddrE      = 32'h0;
        StoreDataE = 32'h0;
        A3E        = a3;
        ALUResE    = res;
    endtask

    // Called at a negedge; returns at the negedge right after the writeback edge.
    task automatic run_vec(input vec_t v, input string tag);
        wb_t e;
        OpE        = v.op;
        AddrE      = v.addr;
        StoreDataE = v.sdata;
        A3E        = v.a3;
        ALUResE    = v.alures;
        e.a3 = v.exp_a3;
        e.wd = v.exp_wd;
        sb.push_back(e);
        @(negedge Clk);
        if (v.delay == 0) begin
            chk({tag, "_stall"}, 32'(StallM), 32'd0);
            chk({tag, "_req"}, 32'(BusReq), 32'd0);
        end else begin
            chk({tag, "_req"}, 32'(BusReq), 32'd1);
            chk({tag, "_we"}, 32'(BusWe), 32'(v.we));
            chk({tag, "_addr"}, BusAddr, {v.addr[31:2], 2'b00});
            if (v.we) begin
                chk({tag, "_be"}, 32'(BusBe), 32'(v.be));
                chk({tag, "_wdata"}, BusWData, v.wdata);
            end
            // E-stage inputs must be ignored while stalled.
            OpE        = c_SW;
            AddrE      = 32'hFFFF_FFFC;
            StoreDataE = 32'h0BAD_0BAD;
            A3E        = 5'd31;
            for (int k = 0; k < v.delay; k++) begin
                chk({tag, "_stall_hi"}, 32'(StallM), 32'd1);
                chk({tag, "_addr_hold"}, BusAddr, {v.addr[31:2], 2'b00});
                BusReady = (k == v.delay - 1);
                BusRData = v.rdata;
                @(negedge Clk);
            end
            BusReady = 1'b0;
            BusRData = 32'hDEAD_DEAD;
            chk({tag, "_stall_lo"}, 32'(StallM), 32'd0);
            chk({tag, "_req_lo"}, 32'(BusReq), 32'd0);
            chk({tag, "_buserr"}, 32'(BusErrM), 32'd0);
        end
        pop_check(tag);
        drive_nop(5'd0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        wb_t  e;

        vecs[0]  = '{c_NOP, 32'h0,     32'h0,          5'd5,  32'h1234,     32'h0,          0, 1'b0, 4'b0000, 32'h0,          5'd5,  32'h0000_1234};
        vecs[1]  = '{4'd12, 32'h40,    32'h0,          5'd7,  32'hDEADBEEF, 32'h0,          0, 1'b0, 4'b0000, 32'h0,          5'd7,  32'hDEAD_BEEF};
        vecs[2]  = '{c_LB,  32'h103,   32'h0,          5'd3,  32'h0,        32'h80FF_FFFF,  3, 1'b0, 4'b0000, 32'h0,          5'd3,  32'hFFFF_FF80};
        vecs[3]  = '{c_LBU, 32'h102,   32'h0,          5'd4,  32'h0,        32'h1280_3456,  1, 1'b0, 4'b0000, 32'h0,          5'd4,  32'h0000_0080};
        vecs[4]  = '{c_LH,  32'h202,   32'h0,          5'd6,  32'h0,        32'h9ABC_1234,  2, 1'b0, 4'b0000, 32'h0,          5'd6,  32'hFFFF_9ABC};
        vecs[5]  = '{c_LHU, 32'h200,   32'h0,          5'd8,  32'h0,        32'h1234_F00D,  1, 1'b0, 4'b0000, 32'h0,          5'd8,  32'h0000_F00D};
        vecs[6]  = '{c_LW,  32'h300,   32'h0,          5'd9,  32'h0,        32'hCAFE_F00D,  2, 1'b0, 4'b0000, 32'h0,          5'd9,  32'hCAFE_F00D};
        vecs[7]  = '{c_SH,  32'h2,     32'hABCD_1234,  5'd10, 32'h0,        32'hFFFF_FFFF,  1, 1'b1, 4'b1100, 32'h1234_1234,  5'd0,  32'h0};
        vecs[8]  = '{c_SB,  32'h401,   32'h0000_00A5,  5'd11, 32'h0,        32'hFFFF_FFFF,  3, 1'b1, 4'b0010, 32'hA5A5_A5A5,  5'd0,  32'h0};
        vecs[9]  = '{c_SW,  32'h504,   32'h1122_3344,  5'd12, 32'h0,        32'hFFFF_FFFF,  2, 1'b1, 4'b1111, 32'h1122_3344,  5'd0,  32'h0};
        vecs[10] = '{c_SH,  32'h600,   32'h5555_BEEF,  5'd13, 32'h0,        32'hFFFF_FFFF,  1, 1'b1, 4'b0011, 32'hBEEF_BEEF,  5'd0,  32'h0};
        vecs[11] = '{c_LH,  32'h2,     32'h0,          5'd14, 32'h0,        32'h7FFF_0000,  1, 1'b0, 4'b0000, 32'h0,          5'd14, 32'h0000_7FFF};
        vecs[12] = '{c_LB,  32'h100,   32'h0,          5'd15, 32'h0,        32'h0000_007F,  2, 1'b0, 4'b0000, 32'h0,          5'd15, 32'h0000_007F};
        vecs[13] = '{c_SB,  32'h403,   32'h1234_5678,  5'd16, 32'h0,        32'hFFFF_FFFF,  1, 1'b1, 4'b1000, 32'h7878_7878,  5'd0,  32'h0};
        // Ready arrives on the same edge the 4-cycle timeout would fire.
        vecs[14] = '{c_LW,  32'h704,   32'h0,          5'd17, 32'h0,        32'h0BAD_F00D,  4, 1'b0, 4'b0000, 32'h0,          5'd17, 32'h0BAD_F00D};

        Reset    = 1'b0;
        BusReady = 1'b0;
        BusRData = 32'h0;
        drive_nop(5'd5, 32'h1234);
        repeat (2) @(negedge Clk);
        chk("rst_req",    32'(BusReq),  32'd0);
        chk("rst_stall",  32'(StallM),  32'd0);
        chk("rst_a3m",    32'(A3M),     32'd0);
        chk("rst_wdm",    WDM,          32'd0);
        chk("rst_buserr", 32'(BusErrM), 32'd0);
        chk("rst_exc",    32'(ExcM),    32'd0);
        chk("rst_addr",   BusAddr,      32'd0);
        chk("rst_be",     32'(BusBe),   32'd0);
        Reset = 1'b1;
        drive_nop(5'd0, 32'h0);
        @(negedge Clk);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: no BusReady for 4 ACCESS cycles.
        OpE   = c_LW;
        AddrE = 32'h700;
        A3E   = 5'd20;
        e.a3 = 5'd0;
        e.wd = 32'h0;
        sb.push_back(e);
        @(negedge Clk);
        chk("to_req", 32'(BusReq), 32'd1);
        drive_nop(5'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("to_stall_hi", 32'(StallM), 32'd1);
            chk("to_buserr_lo", 32'(BusErrM), 32'd0);
            @(negedge Clk);
        end
        chk("to_stall_lo", 32'(StallM), 32'd0);
        chk("to_buserr", 32'(BusErrM), 32'd1);
        chk("to_req_lo", 32'(BusReq), 32'd0);
        pop_check("to");
        @(negedge Clk);
        chk("to_buserr_pulse", 32'(BusErrM), 32'd0);

        // BusReady in IDLE has no effect.
        BusReady = 1'b1;
        BusRData = 32'hFFFF_FFFF;
        drive_nop(5'd3, 32'h55);
        e.a3 = 5'd3;
        e.wd = 32'h55;
        sb.push_back(e);
        @(negedge Clk);
        chk("idle_rdy_req", 32'(BusReq), 32'd0);
        chk("idle_rdy_stall", 32'(StallM), 32'd0);
        pop_check("idle_rdy");
        BusReady = 1'b0;

        // Reset asserted mid-ACCESS.
        OpE   = c_LW;
        AddrE = 32'h800;
        A3E   = 5'd21;
        @(negedge Clk);
        chk("mrst_req_pre", 32'(BusReq), 32'd1);
        drive_nop(5'd9, 32'h99);
        Reset = 1'b0;
        @(negedge Clk);
        chk("mrst_req", 32'(BusReq), 32'd0);
        chk("mrst_stall", 32'(StallM), 32'd0);
        chk("mrst_a3m", 32'(A3M), 32'd0);
        chk("mrst_wdm", WDM, 32'd0);
        chk("mrst_addr", BusAddr, 32'd0);
        Reset = 1'b1;
        drive_nop(5'd0, 32'h0);
        @(negedge Clk);

        // Misaligned word load.
`ifdef MEM_ALIGN_CHECK_EN
        OpE   = c_LW;
        AddrE = 32'h101;
        A3E   = 5'd18;
        e.a3 = 5'd0;
        e.wd = 32'h0;
        sb.push_back(e);
        @(negedge Clk);
        chk("mis_req", 32'(BusReq), 32'd0);
        chk("mis_stall", 32'(StallM), 32'd0);
        chk("mis_exc", 32'(ExcM), 32'd1);
        pop_check("mis");
        drive_nop(5'd0, 32'h0);
        @(negedge Clk);
        chk("mis_exc_pulse", 32'(ExcM), 32'd0);
`else
        v = '{c_LW, 32'h101, 32'h0, 5'd18, 32'h0, 32'h1111_2222, 2, 1'b0, 4'b0000, 32'h0, 5'd18, 32'h1111_2222};
        run_vec(v, "mis");
        chk("mis_exc", 32'(ExcM), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: bus wait cycles before abort; 0 disables the timeout.
REQ-002 SHALL have port Clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port OpE  in  4  memory op from E stage: 0 NOP, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9-15 are treated as NOP.
REQ-005 SHALL have port AddrE  in  32  byte address of the op.
REQ-006 SHALL have port StoreDataE  in  32  store source register value.
REQ-007 SHALL have port A3E  in  5  destination register number.
REQ-008 SHALL have port ALUResE  in  32  result for non-memory instructions.
REQ-009 SHALL have port BusReq, BusWe  out  1  each: bus request and write strobe.
REQ-010 SHALL have port BusAddr  out  32  word-aligned address, with {AddrE[31:2],2'b00}.
REQ-011 SHALL have port BusWData  out  32  replicated store data.
REQ-012 SHALL have port BusBe  out  4  byte enables.
REQ-013 SHALL have port BusReady  in  1  bus completion, sampled in ACCESS.
REQ-014 SHALL have port BusRData  in  32  read data, valid with BusReady.
REQ-015 SHALL have port StallM  out  1  hold E stage and upstream.
REQ-016 SHALL have ports A3M  out  5 and WDM  out  32: destination and data to the W pipeline register.
REQ-017 SHALL have ports BusErrM and ExcM  out  1  each: one-cycle pulses for timeout and misalignment.

Function
REQ-018 SHALL implement FSM IDLE/ACCESS; StallM = (state==ACCESS), decoded from registered state only.
REQ-019 SHALL, in IDLE with a NOP op, register A3M<=A3E and WDM<=ALUResE at the next edge (latency 1).
REQ-020 SHALL, in IDLE with a memory op, go to ACCESS at the next edge with BusReq=1, registered BusWe/BusAddr/BusWData/BusBe, and A3M=0, WDM=0.
REQ-021 SHALL hold all bus outputs stable throughout ACCESS; E inputs are ignored while StallM=1.
REQ-022 SHALL, when BusReady=1 is sampled in ACCESS, go to IDLE at that edge, drop BusReq, and register A3M=dest (0 for stores) and WDM=aligned load data (0 for stores).
REQ-023 SHALL set BusBe to: SW 1111; SH 1100 when AddrE[1]=1, else 0011; SB one-hot at bit AddrE[1:0].
REQ-024 SHALL set BusWData to: the word for SW; {2{half}} for SH; {4{byte}} for SB (little-endian).
REQ-025 SHALL extract loads little-endian: LB/LBU use byte AddrE[1:0], LH/LHU use half AddrE[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-026 SHALL abort when TIMEOUT_CYC>0 and TIMEOUT_CYC cycles elapse in ACCESS without BusReady: go to IDLE, set A3M=0, WDM=0, and pulse BusErrM for 1 cycle.
REQ-027 SHALL let BusReady win when it arrives in the same cycle as the timeout.
REQ-028 SHALL ignore BusReady while in IDLE.

Reset
REQ-029 SHALL, when Reset=0 at an edge, enter IDLE and zero all outputs and the counter, including mid-ACCESS; the bus must tolerate a dropped request.

Configuration
REQ-030 SHALL, with MEM_ALIGN_CHECK_EN defined, not enter ACCESS for a misaligned op (LW/SW with AddrE[1:0]!=0; LH/LHU/SH with AddrE[0]=1); instead it registers A3M=0, WDM=0 and pulses ExcM for 1 cycle.
REQ-031 SHALL, without MEM_ALIGN_CHECK_EN, ignore the misaligned low address bits (truncated alignment) and tie ExcM to 0.

Structure
REQ-032 SHALL keep op codes, state encoding and the BusBe patterns in the shared package mem_access_pkg.
REQ-033 SHALL place the combinational load extract/extend in sub-module mem_load_ext.

Verification
REQ-034 SHALL cover this scenario: OpE=0, A3E=5, ALUResE=0x1234 -> next cycle A3M=5, WDM=0x1234, StallM=0.
REQ-035 SHALL cover this scenario: LB, AddrE=0x103, BusRData=0x80FFFFFF, BusReady after 3 cycles -> StallM high 3 cycles, then WDM=0xFFFFFF80.
REQ-036 SHALL cover this scenario: SH, AddrE=0x2, StoreDataE=0xABCD1234 -> BusBe=1100, BusWData=0x12341234, BusAddr=0x0, A3M=0 on completion.
REQ-037 SHALL cover this scenario: TIMEOUT_CYC=4, no BusReady -> after 4 ACCESS cycles, IDLE, BusErrM pulse, A3M=0.
REQ-038 SHALL cover this scenario: Reset=0 during ACCESS -> next cycle BusReq=0, StallM=0, A3M=0, WDM=0.
REQ-039 SHALL cover this scenario: LW, AddrE=0x101, macro defined -> no BusReq, ExcM pulses; macro undefined -> access proceeds at BusAddr=0x100.
